cache_tag_assoc: RTL and testbench
==================================

# cache_tag_assoc

Parametrised N-way set-associative tag array for the L1 cache controller, successor to the single-port direct-mapped tag store. It stores tag, valid and dirty bits per way per set, and compares all ways in parallel for a same-cycle hit. It tracks true-LRU age per set, nominates a victim way for refills, and clears itself with a cycle-by-cycle sweep after reset or on flush request.

## Interface
- WAYS, 4, associativity; power of 2, 2..8
- SETS, 256, number of sets; power of 2, ≥2
- TAG_W, 20, tag width in bits
- IW = log2(SETS), WW = log2(WAYS) (derived localparams)

- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- flush_i  in  1  start clear sweep (accepted only when ready_o=1)
- ready_o  out  1  array usable; 0 during sweep
- lookup_i  in  1  lookup strobe (LRU touch on hit)
- index_i  in  IW  set index for lookup and write
- tag_i  in  TAG_W  tag to compare
- hit_o  out  1  some valid way in set index_i holds tag_i
- hit_way_o  out  WW  matching way (0 when hit_o=0)
- hit_dirty_o  out  1  dirty bit of hit way (0 when hit_o=0)
- victim_way_o  out  WW  way to replace in set index_i
- victim_valid_o  out  1  victim way's valid bit
- victim_dirty_o  out  1  victim way's dirty bit (write-back needed)
- victim_tag_o  out  TAG_W  victim way's tag (write-back address)
- we_i  in  1  write entry
- wr_way_i  in  WW  way written
- wr_valid_i, wr_dirty_i  in  1 each  new valid/dirty bits
- wr_tag_i  in  TAG_W  new tag

## Operation
- Storage per set/way: {valid, dirty, tag}, plus a WW-bit age. Age 0 = MRU, WAYS-1 = LRU. Ages in a set are always a permutation of 0..WAYS-1.
- Reads are combinational from index_i, matching the existing tag store: hit_o, hit_way_o, hit_dirty_o and the victim outputs settle in the same cycle.
- Hit: valid & tag match. More than one matching way is illegal. If it happens, report the lowest-numbered matching way.
- Victim selection:
  - If any way is invalid, the lowest-numbered invalid way.
  - Otherwise the way with age WAYS-1.
- Touch of way w in set s: every way with age < age[w] increments, then age[w] ← 0.
- Touch triggers:
  - we_i=1 touches wr_way_i.
  - Otherwise lookup_i=1 with hit_o=1 touches hit_way_o.
  - Misses do not touch.
- Write: on the edge with we_i=1 and ready_o=1, set index_i / way wr_way_i ← {wr_valid_i, wr_dirty_i, wr_tag_i}.
- Sweep FSM, states SWEEP and READY:
  - rst_i=1 (any state, including mid-sweep) → SWEEP with counter=0.
  - flush_i=1 in READY → SWEEP with counter=0.
  - In SWEEP, each cycle after reset is released clears set[counter]: all valid=0, dirty=0, tag=0, age[way i]=i. Then counter increments.
  - After set SETS-1 is cleared → READY.
- While ready_o=0, outputs are forced:
  - hit_o=0, hit_way_o=0, hit_dirty_o=0
  - victim_way_o=0, victim_valid_o=0, victim_dirty_o=0, victim_tag_o=0
  - we_i, lookup_i and flush_i are ignored.
- Flush discards dirty state. The controller must write back beforehand.

## Timing
- Reset: ready_o=0 and all outputs 0 during and after reset. ready_o rises exactly SETS cycles after the first edge with rst_i=0. Flush: ready_o=0 from the edge after flush_i, for SETS cycles.
- Lookup latency 0 cycles combinational. Age update is visible the cycle after the touch.
- Write-then-read, same set: new entry visible the cycle after the write edge. Same-cycle lookup sees pre-write contents.
- Simultaneous we_i and lookup hit, same or different set: only the write's way is touched.
- flush_i and we_i in the same READY cycle: flush wins; the write is dropped.
- No wrap: counter stops at SETS-1; the FSM leaves SWEEP on that edge.

## Test plan
- Reset sweep: hold rst_i 3 cycles, release. Require ready_o=0 for 256 cycles, then 1 on cycle 256. Then a lookup at any index gives hit_o=0, victim_way_o=0, victim_valid_o=0.
- Fill and hit:
  - Write ways 0..3 of set 5 with tags 0x10..0x13, valid=1.
  - Lookup tag 0x12 → hit_o=1, hit_way_o=2.
  - Lookup tag 0x99 → hit_o=0, victim_way_o=0 (oldest write), victim_valid_o=1, victim_tag_o=0x10.
- LRU update: after the fill above, lookups hitting ways 0 then 1 → victim_way_o=2. Then a lookup miss → victim unchanged (2).
- Dirty victim: write set 7 way 1 with dirty=1, tag 0xABC. Touch ways 0, 2, 3 via hits. Require victim_way_o=1, victim_dirty_o=1, victim_tag_o=0xABC.
- Flush and collision:
  - Assert flush_i together with we_i in READY. Require the write to be dropped and ready_o=0 for 256 cycles.
  - Assert rst_i at sweep cycle 100. Require a full 256-cycle sweep to restart after release.
- Parameter sweep: repeat fill/LRU with WAYS=2, SETS=4, TAG_W=8 and with WAYS=8, SETS=16. Require the victim sequence to match the reference LRU model over 2000 random accesses.

Source files
------------

// File: rtl/cache_tag_assoc_if.sv
// cache_tag_assoc_if
// Lookup/write/flush bus between the L1 cache controller (master) and the
// set-associative tag array (slave).
//   flush_i      start a clear sweep          ready_o        array usable
//   lookup_i     lookup strobe (LRU touch)    hit_o          tag hit in set
//   index_i      set index                    hit_way_o      matching way
//   tag_i        tag to compare               hit_dirty_o    dirty bit of hit way
//   we_i         write entry                  victim_way_o   replacement way
//   wr_way_i     way written                  victim_valid_o victim valid bit
//   wr_valid_i   new valid bit                victim_dirty_o victim dirty bit
//   wr_dirty_i   new dirty bit                victim_tag_o   victim tag
//   wr_tag_i     new tag
interface cache_tag_assoc_if #(
  parameter int WAYS  = 4,
  parameter int SETS  = 256,
  parameter int TAG_W = 20
);
  localparam int IW = $clog2(SETS);
  localparam int WW = $clog2(WAYS);

  logic             flush_i;
  logic             ready_o;
  logic             lookup_i;
  logic [IW-1:0]    index_i;
  logic [TAG_W-1:0] tag_i;
  logic             hit_o;
  logic [WW-1:0]    hit_way_o;
  logic             hit_dirty_o;
  logic [WW-1:0]    victim_way_o;
  logic             victim_valid_o;
  logic             victim_dirty_o;
  logic [TAG_W-1:0] victim_tag_o;
  logic             we_i;
  logic [WW-1:0]    wr_way_i;
  logic             wr_valid_i;
  logic             wr_dirty_i;
  logic [TAG_W-1:0] wr_tag_i;

  modport master (
    output flush_i, lookup_i, index_i, tag_i, we_i, wr_way_i, wr_valid_i,
           wr_dirty_i, wr_tag_i,
    input  ready_o, hit_o, hit_way_o, hit_dirty_o, victim_way_o,
           victim_valid_o, victim_dirty_o, victim_tag_o
  );

  modport slave (
    input  flush_i, lookup_i, index_i, tag_i, we_i, wr_way_i, wr_valid_i,
           wr_dirty_i, wr_tag_i,
    output ready_o, hit_o, hit_way_o, hit_dirty_o, victim_way_o,
           victim_valid_o, victim_dirty_o, victim_tag_o
  );
endinterface

// File: rtl/cache_tag_assoc.sv
// cache_tag_assoc
// N-way set-associative tag array with true-LRU ages and a victim nominator.
// Reads (hit and victim) are combinational from index_i; writes and LRU
// touches land on the rising edge. After reset or a flush the array clears
// one set per cycle and holds ready_o low until the last set is cleared.
// Ports:
//   clk_i  clock
//   rst_i  synchronous active-high reset (restarts the sweep)
//   bus    cache_tag_assoc_if.slave (lookup/write/flush bus, see interface)
//
// state | meaning
// SWEEP | clearing set cnt_q this cycle; outputs forced to 0, inputs ignored
// READY | array usable; lookups, writes, touches and flush accepted
module cache_tag_assoc #(
  parameter int WAYS  = 4,
  parameter int SETS  = 256,
  parameter int TAG_W = 20
) (
  input logic              clk_i,
  input logic              rst_i,
  cache_tag_assoc_if.slave bus
);
  localparam int IW = $clog2(SETS);
  localparam int WW = $clog2(WAYS);

  typedef enum logic {SWEEP, READY} state_e;

  state_e        state_q;
  logic [IW-1:0] cnt_q;
  logic          ready_q;

  logic             valid_q [SETS][WAYS];
  logic             dirty_q [SETS][WAYS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [WW-1:0]    age_q   [SETS][WAYS];

  logic [IW-1:0] idx;
  logic          hit_raw;
  logic [WW-1:0] hit_way_raw;
  logic          inv_found;
  logic [WW-1:0] inv_way;
  logic [WW-1:0] lru_way;
  logic [WW-1:0] vic_way_raw;
  logic          touch_en;
  logic [WW-1:0] touch_way;
  logic [WW-1:0] age_d [WAYS];

  assign idx = bus.index_i;

  // Lowest-numbered match / invalid way wins, hence the first-found flags.
  always_comb begin
    hit_raw     = 1'b0;
    hit_way_raw = '0;
    inv_found   = 1'b0;
    inv_way     = '0;
    lru_way     = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit_raw && valid_q[idx][w] && (tag_q[idx][w] == bus.tag_i)) begin
        hit_raw     = 1'b1;
        hit_way_raw = WW'(w);
      end
      if (!inv_found && !valid_q[idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WW'(w);
      end
      if (age_q[idx][w] == WW'(WAYS - 1)) begin
        lru_way = WW'(w);
      end
    end
    vic_way_raw = inv_found ? inv_way : lru_way;
  end

  // A write always owns the touch, even when a lookup hits in the same cycle.
  assign touch_en  = ready_q & ~bus.flush_i & (bus.we_i | (bus.lookup_i & hit_raw));
  assign touch_way = bus.we_i ? bus.wr_way_i : hit_way_raw;

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      age_d[w] = age_q[idx][w];
      if (WW'(w) == touch_way) begin
        age_d[w] = '0;
      end else if (age_q[idx][w] < age_q[idx][touch_way]) begin
        age_d[w] = age_q[idx][w] + WW'(1);
      end
    end
  end

  assign bus.ready_o        = ready_q;
  assign bus.hit_o          = ready_q & hit_raw;
  assign bus.hit_way_o      = (ready_q && hit_raw) ? hit_way_raw : '0;
  assign bus.hit_dirty_o    = ready_q & hit_raw & dirty_q[idx][hit_way_raw];
  assign bus.victim_way_o   = ready_q ? vic_way_raw : '0;
  assign bus.victim_valid_o = ready_q & valid_q[idx][vic_way_raw];
  assign bus.victim_dirty_o = ready_q & dirty_q[idx][vic_way_raw];
  assign bus.victim_tag_o   = ready_q ? tag_q[idx][vic_way_raw] : '0;

  // Storage has no reset of its own: the sweep that follows every reset
  // clears it, so only the FSM registers need the reset branch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SWEEP;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        SWEEP: begin
          for (int w = 0; w < WAYS; w++) begin
            valid_q[cnt_q][w] <= 1'b0;
            dirty_q[cnt_q][w] <= 1'b0;
            tag_q[cnt_q][w]   <= '0;
            age_q[cnt_q][w]   <= WW'(w);
          end
          if (cnt_q == IW'(SETS - 1)) begin
            state_q <= READY;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + IW'(1);
          end
        end
        READY: begin
          if (bus.flush_i) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
            ready_q <= 1'b0;
          end else begin
            if (bus.we_i) begin
              valid_q[idx][bus.wr_way_i] <= bus.wr_valid_i;
              dirty_q[idx][bus.wr_way_i] <= bus.wr_dirty_i;
              tag_q[idx][bus.wr_way_i]   <= bus.wr_tag_i;
            end
            if (touch_en) begin
              for (int w = 0; w < WAYS; w++) begin
                age_q[idx][w] <= age_d[w];
              end
            end
          end
        end
        default: begin
          state_q <= SWEEP;
          cnt_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cache_tag_assoc.sv
module tb_cache_tag_assoc;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_tag_assoc_if #(.WAYS(4), .SETS(256), .TAG_W(20)) m_if ();
  cache_tag_assoc_if #(.WAYS(2), .SETS(4),   .TAG_W(8))  a_if ();
  cache_tag_assoc_if #(.WAYS(8), .SETS(16),  .TAG_W(20)) b_if ();

  cache_tag_assoc #(.WAYS(4), .SETS(256), .TAG_W(20)) u_main (.clk_i(clk), .rst_i(rst), .bus(m_if.slave));
  cache_tag_assoc #(.WAYS(2), .SETS(4),   .TAG_W(8))  u_a    (.clk_i(clk), .rst_i(rst), .bus(a_if.slave));
  cache_tag_assoc #(.WAYS(8), .SETS(16),  .TAG_W(20)) u_b    (.clk_i(clk), .rst_i(rst), .bus(b_if.slave));

  // Shared random stream for the two small configurations.
  logic       r_lookup, r_we, r_valid, r_dirty;
  logic [3:0] r_index;
  logic [2:0] r_way;
  logic [7:0] r_tag;

  assign a_if.flush_i    = 1'b0;
  assign a_if.lookup_i   = r_lookup;
  assign a_if.index_i    = r_index[1:0];
  assign a_if.tag_i      = r_tag;
  assign a_if.we_i       = r_we;
  assign a_if.wr_way_i   = r_way[0];
  assign a_if.wr_valid_i = r_valid;
  assign a_if.wr_dirty_i = r_dirty;
  assign a_if.wr_tag_i   = r_tag;

  assign b_if.flush_i    = 1'b0;
  assign b_if.lookup_i   = r_lookup;
  assign b_if.index_i    = r_index;
  assign b_if.tag_i      = {12'b0, r_tag};
  assign b_if.we_i       = r_we;
  assign b_if.wr_way_i   = r_way;
  assign b_if.wr_valid_i = r_valid;
  assign b_if.wr_dirty_i = r_dirty;
  assign b_if.wr_tag_i   = {12'b0, r_tag};

  typedef struct {
    int          dut;
    string       name;
    logic [30:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  // {ready, hit, hit_way, hit_dirty, victim_way, victim_valid, victim_dirty, victim_tag}
  function automatic logic [30:0] pk(logic r, logic h, logic [2:0] hw, logic hd,
                                     logic [2:0] vw, logic vv, logic vd, logic [19:0] vt);
    return {r, h, hw, hd, vw, vv, vd, vt};
  endfunction

  localparam logic [30:0] ZERO  = 31'h0;
  localparam logic [30:0] RDY_0 = {1'b1, 30'h0};

  sb_t         mon_e;
  logic [30:0] mon_act;

  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      case (mon_e.dut)
        0: mon_act = pk(m_if.ready_o, m_if.hit_o, {1'b0, m_if.hit_way_o}, m_if.hit_dirty_o,
                        {1'b0, m_if.victim_way_o}, m_if.victim_valid_o, m_if.victim_dirty_o,
                        m_if.victim_tag_o);
        1: mon_act = pk(a_if.ready_o, a_if.hit_o, {2'b0, a_if.hit_way_o}, a_if.hit_dirty_o,
                        {2'b0, a_if.victim_way_o}, a_if.victim_valid_o, a_if.victim_dirty_o,
                        {12'b0, a_if.victim_tag_o});
        default: mon_act = pk(b_if.ready_o, b_if.hit_o, b_if.hit_way_o, b_if.hit_dirty_o,
                              b_if.victim_way_o, b_if.victim_valid_o, b_if.victim_dirty_o,
                              b_if.victim_tag_o);
      endcase
      n_cmp++;
      if (mon_act !== mon_e.exp) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", mon_e.name, mon_act, mon_e.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(string nm, logic exp_v, logic act);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp_v);
    end
  endtask

  task automatic push(int d, string nm, logic [30:0] e);
    sb_t t;
    t.dut  = d;
    t.name = nm;
    t.exp  = e;
    sb_q.push_back(t);
  endtask

  task automatic chk(string nm, logic [30:0] e);
    push(0, nm, e);
  endtask

  task automatic drv(logic lk, logic [7:0] ix, logic [19:0] t);
    m_if.flush_i  = 1'b0;
    m_if.we_i     = 1'b0;
    m_if.lookup_i = lk;
    m_if.index_i  = ix;
    m_if.tag_i    = t;
  endtask

  task automatic wr(logic [7:0] ix, logic [1:0] w, logic v, logic d, logic [19:0] t);
    m_if.flush_i    = 1'b0;
    m_if.we_i       = 1'b1;
    m_if.lookup_i   = 1'b0;
    m_if.index_i    = ix;
    m_if.wr_way_i   = w;
    m_if.wr_valid_i = v;
    m_if.wr_dirty_i = d;
    m_if.wr_tag_i   = t;
  endtask

  // Reference model for the small configurations: recency list per set
  // (position 0 = most recent), victim = lowest invalid way else list tail.
  int mw[3] = '{4, 2, 8};
  int ms[3] = '{256, 4, 16};
  bit md_valid[3][16][8];
  bit md_dirty[3][16][8];
  int md_tag[3][16][8];
  int md_ord[3][16][8];

  task automatic model_clear();
    for (int d = 1; d < 3; d++)
      for (int s = 0; s < 16; s++)
        for (int w = 0; w < 8; w++) begin
          md_valid[d][s][w] = 1'b0;
          md_dirty[d][s][w] = 1'b0;
          md_tag[d][s][w]   = 0;
          md_ord[d][s][w]   = w;
        end
  endtask

  function automatic logic [30:0] model_exp(int d, int s, int t);
    int  hw = 0, vw = -1;
    logic h = 1'b0;
    for (int w = 0; w < mw[d]; w++) begin
      if (!h && md_valid[d][s][w] && md_tag[d][s][w] == t) begin
        h  = 1'b1;
        hw = w;
      end
      if (vw < 0 && !md_valid[d][s][w]) vw = w;
    end
    if (vw < 0) vw = md_ord[d][s][mw[d]-1];
    return pk(1'b1, h, 3'(hw), h & md_dirty[d][s][hw], 3'(vw),
              md_valid[d][s][vw], md_dirty[d][s][vw], 20'(md_tag[d][s][vw]));
  endfunction

  task automatic model_touch(int d, int s, int w);
    int p = 0;
    for (int q = 0; q < mw[d]; q++) if (md_ord[d][s][q] == w) p = q;
    for (int q = p; q > 0; q--) md_ord[d][s][q] = md_ord[d][s][q-1];
    md_ord[d][s][0] = w;
  endtask

  initial begin
    logic [30:0] e;
    int s, w;
    rst = 1'b1;
    r_lookup = 1'b0; r_we = 1'b0; r_valid = 1'b0; r_dirty = 1'b0;
    r_index = '0; r_way = '0; r_tag = '0;
    m_if.wr_way_i = '0; m_if.wr_valid_i = 1'b0; m_if.wr_dirty_i = 1'b0; m_if.wr_tag_i = '0;
    drv(1'b0, 8'd0, 20'h0);

    // Reset and initial sweep
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_hold", ZERO);
    end
    expect_now("reset_state_ready_low", 1'b0, m_if.ready_o);
    rst = 1'b0;
    drv(1'b1, 8'd33, 20'h0);
    for (int k = 0; k < 256; k++) begin
      chk("reset_sweep", ZERO);
      if (k == 255) expect_now("sweep_last_cycle_low", 1'b0, m_if.ready_o);
      step();
    end
    expect_now("sweep_expired_ready_high", 1'b1, m_if.ready_o);
    chk("reset_ready", RDY_0);
    drv(1'b1, 8'd200, 20'h5);
    chk("empty_lookup", RDY_0);
    step();

    // Fill set 5; the tag_i probe of 0x10 shows write visibility timing
    for (int i = 0; i < 4; i++) begin
      wr(8'd5, 2'(i), 1'b1, 1'b0, 20'h10 + 20'(i));
      m_if.tag_i = 20'h10;
      chk("fill_probe", pk(1'b1, i > 0, 3'd0, 1'b0, 3'(i), 1'b0, 1'b0, 20'h0));
      step();
    end
    drv(1'b0, 8'd5, 20'h12);
    chk("hit_way2", pk(1'b1, 1'b1, 3'd2, 1'b0, 3'd0, 1'b1, 1'b0, 20'h10));
    step();
    drv(1'b1, 8'd5, 20'h99);
    chk("miss_victim0", pk(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0, 20'h10));
    step();
    drv(1'b1, 8'd5, 20'h10);
    chk("touch_way0", pk(1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0, 20'h10));
    step();
    drv(1'b1, 8'd5, 20'h11);
    chk("touch_way1", pk(1'b1, 1'b1, 3'd1, 1'b0, 3'd1, 1'b1, 1'b0, 20'h11));
    step();
    drv(1'b1, 8'd5, 20'h99);
    chk("lru_victim2", pk(1'b1, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0, 20'h12));
    step();
    chk("miss_no_touch", pk(1'b1, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0, 20'h12));
    step();

    // Dirty victim in set 7
    wr(8'd7, 2'd1, 1'b1, 1'b1, 20'hABC);
    m_if.tag_i = 20'hABC;
    chk("write_pre_contents", RDY_0);
    step();
    wr(8'd7, 2'd0, 1'b1, 1'b0, 20'h100);
    m_if.tag_i = 20'hABC;
    chk("write_visible_dirty", pk(1'b1, 1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 1'b0, 20'h0));
    step();
    wr(8'd7, 2'd2, 1'b1, 1'b0, 20'h102);
    step();
    wr(8'd7, 2'd3, 1'b1, 1'b0, 20'h103);
    step();
    drv(1'b1, 8'd7, 20'h100);
    chk("dv_hit0", pk(1'b1, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 1'b1, 20'hABC));
    step();
    drv(1'b1, 8'd7, 20'h102);
    chk("dv_hit2", pk(1'b1, 1'b1, 3'd2, 1'b0, 3'd1, 1'b1, 1'b1, 20'hABC));
    step();
    drv(1'b1, 8'd7, 20'h103);
    chk("dv_hit3", pk(1'b1, 1'b1, 3'd3, 1'b0, 3'd1, 1'b1, 1'b1, 20'hABC));
    step();
    drv(1'b0, 8'd7, 20'h5);
    chk("dirty_victim", pk(1'b1, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b1, 20'hABC));
    step();

    // Write and lookup hit together: only the written way is touched
    wr(8'd7, 2'd1, 1'b1, 1'b0, 20'hABC);
    m_if.lookup_i = 1'b1;
    m_if.tag_i    = 20'h103;
    chk("we_and_hit_pre", pk(1'b1, 1'b1, 3'd3, 1'b0, 3'd1, 1'b1, 1'b1, 20'hABC));
    step();
    drv(1'b0, 8'd7, 20'hABC);
    chk("we_owns_touch", pk(1'b1, 1'b1, 3'd1, 1'b0, 3'd0, 1'b1, 1'b0, 20'h100));
    step();

    // Flush with simultaneous write; writes during the sweep are ignored
    wr(8'd5, 2'd0, 1'b1, 1'b0, 20'h55);
    m_if.flush_i = 1'b1;
    m_if.tag_i   = 20'h55;
    chk("flush_pre", pk(1'b1, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0, 20'h12));
    step();
    drv(1'b1, 8'd5, 20'h12);
    for (int k = 0; k < 256; k++) begin
      if (k == 100) begin
        wr(8'd3, 2'd1, 1'b1, 1'b1, 20'h77);
        m_if.flush_i = 1'b1;
      end else if (k == 101) begin
        drv(1'b1, 8'd5, 20'h12);
      end
      chk("flush_sweep", ZERO);
      step();
    end
    drv(1'b0, 8'd3, 20'h77);
    chk("sweep_write_ignored", RDY_0);
    step();
    drv(1'b0, 8'd5, 20'h55);
    chk("flush_write_dropped", RDY_0);
    step();
    drv(1'b0, 8'd7, 20'hABC);
    chk("flush_cleared_set7", RDY_0);
    step();

    // Reset at sweep cycle 100 restarts a full sweep
    m_if.flush_i = 1'b1;
    step();
    m_if.flush_i = 1'b0;
    for (int k = 0; k < 100; k++) begin
      chk("pre_rst_sweep", ZERO);
      step();
    end
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      chk("mid_sweep_rst", ZERO);
      step();
    end
    rst = 1'b0;
    for (int k = 0; k < 256; k++) begin
      chk("resweep", ZERO);
      step();
    end
    expect_now("resweep_expired_ready_high", 1'b1, m_if.ready_o);
    chk("resweep_ready", RDY_0);
    step();

    // Small configurations against the recency-list model
    model_clear();
    for (int i = 0; i < 2000; i++) begin
      r_index  = 4'($urandom_range(0, 15));
      r_way    = 3'($urandom_range(0, 7));
      r_tag    = 8'($urandom_range(0, 5));
      r_valid  = ($urandom_range(0, 3) != 0);
      r_dirty  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       begin r_we = 1'b1; r_lookup = 1'b0; end
        1:       begin r_we = 1'b0; r_lookup = 1'b1; end
        default: begin r_we = 1'b0; r_lookup = 1'b0; end
      endcase
      for (int d = 1; d < 3; d++) begin
        s = int'(r_index) % ms[d];
        w = int'(r_way) % mw[d];
        e = model_exp(d, s, int'(r_tag));
        push(d, $sformatf("rnd%0d_cfg%0d", i, d), e);
        if (r_we) begin
          md_valid[d][s][w] = r_valid;
          md_dirty[d][s][w] = r_dirty;
          md_tag[d][s][w]   = int'(r_tag);
          model_touch(d, s, w);
        end else if (r_lookup && e[29]) begin
          model_touch(d, s, int'(e[28:26]));
        end
      end
      step();
    end
    r_we = 1'b0;
    r_lookup = 1'b0;
    step();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
